// File: rtl/arbi_req_master.sv
// Requesting master for a two-port arbiter: buffers local writes in a FIFO and
// presents the head entry with a registered req until the arbiter grants it.
module arbi_req_master #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int MAX_WAIT   = 15
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    req,
  output logic [DATA_WIDTH-1:0]   data_out,
  input  logic                    grant,
  output logic                    starve,
  output logic [15:0]             sent_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int WW = $clog2(MAX_WAIT + 1);

  typedef enum logic {IDLE, REQ} state_t;

  state_t                  state;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic [AW-1:0]           wr_ptr, rd_ptr;
  logic [WW-1:0]           wait_cnt;
  logic                    push, pop;

  // full is the pre-edge occupancy, so a pop at the same edge never frees a slot for this push
  assign push  = wr_en && !full;
  assign pop   = (state == REQ) && grant;
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign starve = (wait_cnt == WW'(MAX_WAIT));
  assign data_out = req ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      sent_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr   <= rd_ptr + 1'b1;
        sent_cnt <= sent_cnt + 16'd1;
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      req   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (count != '0) begin
          state <= REQ;
          req   <= 1'b1;
        end
        REQ: if (pop && count == CW'(1) && !push) begin
          state <= IDLE;
          req   <= 1'b0;
        end
        default: begin
          state <= IDLE;
          req   <= 1'b0;
        end
      endcase
    end
  end

  // A pop is the only way out of REQ, so clearing on pop also covers entry to IDLE
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      wait_cnt <= '0;
    else if (pop || state == IDLE)
      wait_cnt <= '0;
    else if (wait_cnt != WW'(MAX_WAIT))
      wait_cnt <= wait_cnt + 1'b1;
  end
endmodule

// File: tb/tb_arbi_req_master.sv
// Bench for arbi_req_master: directed scenarios plus random traffic, all checked
// each cycle against a queue-based transaction model.
module tb_arbi_req_master;
  localparam int DW = 32;
  localparam int DEPTH = 4;
  localparam int MAX_WAIT = 15;

  logic clk = 1'b0;
  logic reset;
  logic wr_en, grant;
  logic [DW-1:0] wr_data;
  logic full, empty, req, starve;
  logic [$clog2(DEPTH):0] count;
  logic [DW-1:0] data_out;
  logic [15:0] sent_cnt;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] q[$];
  bit  m_req;
  int  m_wait;
  int  m_sent;

  always #5 clk = ~clk;

  arbi_req_master #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .empty(empty), .count(count), .req(req), .data_out(data_out),
    .grant(grant), .starve(starve), .sent_cnt(sent_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_req = 0;
    m_wait = 0;
    m_sent = 0;
  endtask

  // Transaction-level view of one rising edge with the given inputs
  task automatic model_edge(input logic we, input logic [DW-1:0] wd, input logic gr);
    int  sz;
    bit  psh, pp;
    sz  = q.size();
    psh = we && (sz < DEPTH);
    pp  = m_req && gr;
    if (pp) begin
      void'(q.pop_front());
      m_sent = (m_sent + 1) % 65536;
    end
    if (psh) q.push_back(wd);
    if (pp || !m_req) m_wait = 0;
    else if (m_wait < MAX_WAIT) m_wait++;
    if (!m_req) m_req = (sz > 0);
    else if (pp && sz == 1 && !psh) m_req = 0;
  endtask

  task automatic check_all(input string ph);
    chk({ph, ":req"}, 64'(req), 64'(m_req));
    chk({ph, ":data_out"}, 64'(data_out), m_req ? 64'(q[0]) : 64'd0);
    chk({ph, ":count"}, 64'(count), 64'(q.size()));
    chk({ph, ":full"}, 64'(full), 64'(q.size() == DEPTH));
    chk({ph, ":empty"}, 64'(empty), 64'(q.size() == 0));
    chk({ph, ":starve"}, 64'(starve), 64'(m_wait == MAX_WAIT));
    chk({ph, ":sent_cnt"}, 64'(sent_cnt), 64'(m_sent));
  endtask

  // Called at a falling edge: drive inputs, take one rising edge, check at the next falling edge
  task automatic cycle(input string ph, input logic we, input logic [DW-1:0] wd, input logic gr);
    wr_en = we; wr_data = wd; grant = gr;
    @(posedge clk);
    model_edge(we, wd, gr);
    @(negedge clk);
    check_all(ph);
  endtask

  task automatic async_reset(input string ph);
    #2 reset = 1'b0;
    #1 model_reset();
    check_all(ph);
    @(negedge clk);
    wr_en = 1'b0; grant = 1'b0;
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; wr_en = 1'b0; grant = 1'b0; wr_data = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all("reset");
    reset = 1'b1;

    // single transfer
    cycle("single", 1'b1, 32'hA5A5_0001, 1'b0);
    cycle("single", 1'b0, 32'h0, 1'b0);
    chk("single_req", 64'(req), 64'd1);
    chk("single_data", 64'(data_out), 64'hA5A5_0001);
    cycle("single", 1'b0, 32'h0, 1'b1);
    chk("single_sent", 64'(sent_cnt), 64'd1);
    cycle("idle_grant", 1'b0, 32'h0, 1'b1);

    // burst
    for (int i = 1; i <= 4; i++) cycle("burst_fill", 1'b1, 32'(i * 'h11), 1'b0);
    for (int i = 0; i < 5; i++) cycle("burst_drain", 1'b0, 32'h0, 1'b1);

    // overflow
    for (int i = 1; i <= 5; i++) cycle("ovf_fill", 1'b1, 32'(i), 1'b0);
    chk("ovf_count", 64'(count), 64'd4);
    chk("ovf_full", 64'(full), 64'd1);
    for (int i = 0; i < 5; i++) cycle("ovf_drain", 1'b0, 32'h0, 1'b1);

    // starvation
    cycle("starve", 1'b1, 32'hBEEF, 1'b0);
    for (int i = 0; i < 20; i++) cycle("starve", 1'b0, 32'h0, 1'b0);
    chk("starve_hi", 64'(starve), 64'd1);
    cycle("starve_rel", 1'b0, 32'h0, 1'b1);
    chk("starve_lo", 64'(starve), 64'd0);

    // reset mid-operation
    for (int i = 0; i < 3; i++) cycle("mid_fill", 1'b1, 32'(100 + i), 1'b0);
    async_reset("mid_reset");
    for (int i = 0; i < 4; i++) cycle("post_reset", 1'b0, 32'h0, 1'b1);

    // random traffic
    for (int i = 0; i < 600; i++)
      cycle("rand", 1'(($urandom_range(0, 9)) < 6), $urandom, 1'(($urandom_range(0, 9)) < 4));
    async_reset("rand_reset");
    for (int i = 0; i < 200; i++)
      cycle("rand2", 1'($urandom_range(0, 1)), $urandom, 1'(($urandom_range(0, 9)) < 7));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
